// File: rtl/scroll_sequencer.sv
// Frame-synchronous scroll offset sequencer: IDLE -> SCROLL_X -> SCROLL_Y -> HOLD -> SCROLL_X ...
// Optional macro SCROLL_SEQ_BOUNCE_EN makes scroll_x bounce between 0 and X_LIMIT instead of wrapping.
module scroll_sequencer #(
    parameter int SEG_FRAMES        = 120,
    parameter int HOLD_FRAMES       = 30,
    parameter int VSYNC_ACTIVE_HIGH = 0,
    parameter int X_LIMIT           = 639
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        enable,
    input  logic        pause,
    input  logic        restart,
    input  logic [2:0]  speed,
    input  logic        dir,
    output logic [9:0]  scroll_x,
    output logic [9:0]  scroll_y,
    output logic [1:0]  phase,
    output logic        frame_tick,
    output logic [15:0] frame_count
);

    localparam logic       VS_ACTIVE = (VSYNC_ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;
    localparam logic [7:0] SEG_LAST  = 8'(SEG_FRAMES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SCROLL_X = 2'd1,
        ST_SCROLL_Y = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  seg_cnt_r;
    logic [7:0]  seg_cnt_nxt_s;
    logic        vsync_q_r;
    logic        tick_s;
    logic        run_s;
    logic [9:0]  step_s;
    logic [9:0]  scroll_x_r;
    logic [9:0]  scroll_y_r;
    logic [9:0]  x_nxt_s;
    logic [9:0]  y_nxt_s;
    logic        frame_tick_r;
    logic [15:0] frame_count_r;

    // Modulo-1024 step in either direction.
    function automatic logic [9:0] step_wrap(input logic [9:0] value, input logic [9:0] step,
                                             input logic dec);
        logic [9:0] res;
        if (dec) begin
            res = value - step;
        end else begin
            res = value + step;
        end
        return res;
    endfunction

    assign tick_s = (vsync == VS_ACTIVE) && (vsync_q_r != VS_ACTIVE);
    assign run_s  = tick_s && enable && !pause;
    assign step_s = {7'd0, speed} + 10'd1;

`ifdef SCROLL_SEQ_BOUNCE_EN
    localparam logic [10:0] X_MAX = 11'(X_LIMIT);

    logic        xdir_r;
    logic        xdir_nxt_s;
    logic [10:0] fwd_sum_s;

    assign fwd_sum_s = {1'b0, scroll_x_r} + {1'b0, step_s};

    // Bounce direction register; cleared by restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xdir_r <= 1'b0;
        end else begin
            xdir_r <= xdir_nxt_s;
        end
    end
`endif

    // State and segment counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            seg_cnt_r <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            seg_cnt_r <= seg_cnt_nxt_s;
        end
    end

    // Next-state and segment count; restart beats a coincident tick.
    always_comb begin
        state_nxt_s   = state_r;
        seg_cnt_nxt_s = seg_cnt_r;
        if (restart) begin
            state_nxt_s   = ST_IDLE;
            seg_cnt_nxt_s = 8'd0;
        end else if (tick_s) begin
            if (!enable) begin
                state_nxt_s   = ST_IDLE;
                seg_cnt_nxt_s = 8'd0;
            end else if (pause) begin
                state_nxt_s   = state_r;
                seg_cnt_nxt_s = seg_cnt_r;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_nxt_s   = ST_SCROLL_X;
                        seg_cnt_nxt_s = 8'd0;
                    end
                    ST_SCROLL_X: begin
                        if (seg_cnt_r == SEG_LAST) begin
                            state_nxt_s   = ST_SCROLL_Y;
                            seg_cnt_nxt_s = 8'd0;
                        end else begin
                            seg_cnt_nxt_s = seg_cnt_r + 8'd1;
                        end
                    end
                    ST_SCROLL_Y: begin
                        if (seg_cnt_r == SEG_LAST) begin
                            state_nxt_s   = ST_HOLD;
                            seg_cnt_nxt_s = 8'd0;
                        end else begin
                            seg_cnt_nxt_s = seg_cnt_r + 8'd1;
                        end
                    end
                    ST_HOLD: begin
                        if (seg_cnt_r == HOLD_LAST) begin
                            state_nxt_s   = ST_SCROLL_X;
                            seg_cnt_nxt_s = 8'd0;
                        end else begin
                            seg_cnt_nxt_s = seg_cnt_r + 8'd1;
                        end
                    end
                    default: begin
                        state_nxt_s   = ST_IDLE;
                        seg_cnt_nxt_s = 8'd0;
                    end
                endcase
            end
        end else begin
            state_nxt_s   = state_r;
            seg_cnt_nxt_s = seg_cnt_r;
        end
    end

    // Next offsets: only a running tick in a scroll state moves them.
    always_comb begin
        x_nxt_s = scroll_x_r;
        y_nxt_s = scroll_y_r;
`ifdef SCROLL_SEQ_BOUNCE_EN
        xdir_nxt_s = xdir_r;
`endif
        if (restart) begin
            x_nxt_s = 10'd0;
            y_nxt_s = 10'd0;
`ifdef SCROLL_SEQ_BOUNCE_EN
            xdir_nxt_s = 1'b0;
`endif
        end else if (run_s) begin
            case (state_r)
                ST_IDLE: begin
`ifdef SCROLL_SEQ_BOUNCE_EN
                    xdir_nxt_s = dir;
`endif
                    x_nxt_s = scroll_x_r;
                end
                ST_SCROLL_X: begin
`ifdef SCROLL_SEQ_BOUNCE_EN
                    if (!xdir_r) begin
                        if (fwd_sum_s > X_MAX) begin
                            x_nxt_s    = X_MAX[9:0];
                            xdir_nxt_s = 1'b1;
                        end else begin
                            x_nxt_s = fwd_sum_s[9:0];
                        end
                    end else begin
                        if (scroll_x_r < step_s) begin
                            x_nxt_s    = 10'd0;
                            xdir_nxt_s = 1'b0;
                        end else begin
                            x_nxt_s = scroll_x_r - step_s;
                        end
                    end
`else
                    x_nxt_s = step_wrap(scroll_x_r, step_s, dir);
`endif
                end
                ST_SCROLL_Y: begin
                    y_nxt_s = step_wrap(scroll_y_r, step_s, dir);
                end
                default: begin
                    x_nxt_s = scroll_x_r;
                    y_nxt_s = scroll_y_r;
                end
            endcase
        end else begin
            x_nxt_s = scroll_x_r;
            y_nxt_s = scroll_y_r;
        end
    end

    // Offsets, vsync delay, tick pulse and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q_r     <= ~VS_ACTIVE;
            scroll_x_r    <= 10'd0;
            scroll_y_r    <= 10'd0;
            frame_tick_r  <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            vsync_q_r    <= vsync;
            scroll_x_r   <= x_nxt_s;
            scroll_y_r   <= y_nxt_s;
            frame_tick_r <= tick_s && !restart;
            if (tick_s && !restart) begin
                frame_count_r <= frame_count_r + 16'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign scroll_x    = scroll_x_r;
    assign scroll_y    = scroll_y_r;
    assign phase       = state_r;
    assign frame_tick  = frame_tick_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Scoreboard bench for scroll_sequencer (SEG_FRAMES=4, HOLD_FRAMES=2, active-low vsync).
module tb_scroll_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vsync;
    logic        enable;
    logic        pause;
    logic        restart;
    logic [2:0]  speed;
    logic        dir;
    logic [9:0]  scroll_x;
    logic [9:0]  scroll_y;
    logic [1:0]  phase;
    logic        frame_tick;
    logic [15:0] frame_count;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [1:0]  ph;
        logic [15:0] fc;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_fc = 16'd0;

    scroll_sequencer #(
        .SEG_FRAMES(4),
        .HOLD_FRAMES(2),
        .VSYNC_ACTIVE_HIGH(0),
        .X_LIMIT(639)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .enable(enable), .pause(pause),
        .restart(restart), .speed(speed), .dir(dir), .scroll_x(scroll_x),
        .scroll_y(scroll_y), .phase(phase), .frame_tick(frame_tick), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // One frame: drive controls with a vsync falling edge, expect the registered result.
    task automatic do_tick(input logic en, input logic pa, input logic [2:0] sp, input logic d,
                           input logic [9:0] ex, input logic [9:0] ey, input logic [1:0] eph);
        exp_t e;
        exp_t got;
        int   waited;
        @(negedge clk);
        enable = en; pause = pa; speed = sp; dir = d; vsync = 1'b0;
        exp_fc = exp_fc + 16'd1;
        e.x = ex; e.y = ey; e.ph = eph; e.fc = exp_fc;
        exp_q.push_back(e);
        @(negedge clk);
        waited = 0;
        while (frame_tick !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        e = exp_q.pop_front();
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL tick_timeout: frame_tick=%b required 1", frame_tick);
        end else begin
            got.x = scroll_x; got.y = scroll_y; got.ph = phase; got.fc = frame_count;
            if (got !== e)
                errors++;
            if (got !== e)
                $display("FAIL tick_result: x=%0d y=%0d phase=%0d fc=%0d required x=%0d y=%0d phase=%0d fc=%0d",
                         scroll_x, scroll_y, phase, frame_count, e.x, e.y, e.ph, e.fc);
        end
        speed = ~sp; dir = ~d;
        @(negedge clk);
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_pulse_width: frame_tick=%b required 0", frame_tick);
        end
        vsync = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({scroll_x, scroll_y, phase, frame_tick, frame_count} !== 39'd0) begin
            errors++;
            $display("FAIL %s: x=%0d y=%0d phase=%0d tick=%b fc=%0d required all 0",
                     name, scroll_x, scroll_y, phase, frame_tick, frame_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vsync = 1'b1; enable = 1'b0; pause = 1'b0; restart = 1'b0;
        speed = 3'd0; dir = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst_n = 1'b1;
        exp_fc = 16'd0;
        repeat (2) @(negedge clk);
        check_zero("after_reset_idle");
    endtask

    task automatic test_sequence();
        do_tick(1'b1, 1'b0, 3'd0, 1'b0, 10'd0, 10'd0, 2'd1);
        for (int i = 1; i <= 4; i++)
            do_tick(1'b1, 1'b0, 3'd0, 1'b0, 10'(i), 10'd0, (i == 4) ? 2'd2 : 2'd1);
        for (int i = 1; i <= 4; i++)
            do_tick(1'b1, 1'b0, 3'd0, 1'b0, 10'd4, 10'(i), (i == 4) ? 2'd3 : 2'd2);
        do_tick(1'b1, 1'b0, 3'd0, 1'b0, 10'd4, 10'd4, 2'd3);
        do_tick(1'b1, 1'b0, 3'd0, 1'b0, 10'd4, 10'd4, 2'd1);
        checks++;
        if (frame_count !== 16'd11) begin
            errors++;
            $display("FAIL seq_frame_count: fc=%0d required 11", frame_count);
        end
    endtask

    task automatic test_restart_collision();
        do_tick(1'b1, 1'b0, 3'd7, 1'b0, 10'd12, 10'd4, 2'd1);
        @(negedge clk);
        restart = 1'b1; vsync = 1'b0;
        @(negedge clk);
        restart = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({scroll_x, scroll_y, phase, frame_tick} !== 23'd0 || frame_count !== exp_fc) begin
                errors++;
                $display("FAIL restart_collision: x=%0d y=%0d phase=%0d tick=%b fc=%0d required 0 0 0 0 fc=%0d",
                         scroll_x, scroll_y, phase, frame_tick, frame_count, exp_fc);
            end
            @(negedge clk);
        end
        vsync = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        do_tick(1'b1, 1'b0, 3'd0, 1'b0, 10'd0,    10'd0, 2'd1);
        do_tick(1'b1, 1'b0, 3'd3, 1'b1, 10'd1020, 10'd0, 2'd1);
        do_tick(1'b1, 1'b0, 3'd7, 1'b0, 10'd4,    10'd0, 2'd1);
        do_tick(1'b1, 1'b0, 3'd0, 1'b1, 10'd3,    10'd0, 2'd1);
        do_tick(1'b1, 1'b0, 3'd7, 1'b1, 10'd1019, 10'd0, 2'd2);
    endtask

    task automatic test_pause_disable();
        do_tick(1'b1, 1'b0, 3'd7, 1'b0, 10'd1019, 10'd8,  2'd2);
        do_tick(1'b1, 1'b0, 3'd1, 1'b0, 10'd1019, 10'd10, 2'd2);
        for (int i = 0; i < 3; i++)
            do_tick(1'b1, 1'b1, 3'd7, 1'b0, 10'd1019, 10'd10, 2'd2);
        do_tick(1'b1, 1'b0, 3'd0, 1'b0, 10'd1019, 10'd11, 2'd2);
        do_tick(1'b1, 1'b0, 3'd0, 1'b0, 10'd1019, 10'd12, 2'd3);
        do_tick(1'b0, 1'b0, 3'd7, 1'b0, 10'd1019, 10'd12, 2'd0);
    endtask

    task automatic test_stable_between_ticks();
        do_tick(1'b1, 1'b0, 3'd0, 1'b0, 10'd1019, 10'd12, 2'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (scroll_x !== 10'd1019 || scroll_y !== 10'd12 || phase !== 2'd1 ||
                frame_tick !== 1'b0 || frame_count !== exp_fc) begin
                errors++;
                $display("FAIL stable_between_ticks: x=%0d y=%0d phase=%0d tick=%b fc=%0d required 1019 12 1 0 %0d",
                         scroll_x, scroll_y, phase, frame_tick, frame_count, exp_fc);
            end
            enable = 1'($urandom); pause = 1'($urandom);
            speed = 3'($urandom); dir = 1'($urandom);
        end
    endtask

    task automatic test_async_reset();
        do_tick(1'b1, 1'b0, 3'd7, 1'b0, 10'd3, 10'd12, 2'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset_no_edge");
        exp_fc = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef SCROLL_SEQ_BOUNCE_EN
    task automatic test_bounce();
        logic [9:0] xe;
        logic [9:0] ye;
        xe = 10'd0; ye = 10'd0;
        do_tick(1'b1, 1'b0, 3'd0, 1'b0, xe, ye, 2'd1);
        for (int k = 0; k < 20; k++) begin
            for (int s = 0; s < 4; s++) begin
                xe = xe + ((k == 19 && s == 3) ? 10'd4 : 10'd8);
                do_tick(1'b1, 1'b0, (k == 19 && s == 3) ? 3'd3 : 3'd7, 1'(s), xe, ye,
                        (s == 3) ? 2'd2 : 2'd1);
            end
            for (int s = 0; s < 4; s++) begin
                ye = ye + 10'd8;
                do_tick(1'b1, 1'b0, 3'd7, 1'b0, xe, ye, (s == 3) ? 2'd3 : 2'd2);
            end
            do_tick(1'b1, 1'b0, 3'd7, 1'b0, xe, ye, 2'd3);
            do_tick(1'b1, 1'b0, 3'd7, 1'b0, xe, ye, 2'd1);
        end
        do_tick(1'b1, 1'b0, 3'd7, 1'b0, 10'd639, ye, 2'd1);
        do_tick(1'b1, 1'b0, 3'd7, 1'b0, 10'd631, ye, 2'd1);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        do_tick(1'b1, 1'b0, 3'd0, 1'b0, 10'd0, 10'd0, 2'd1);
        do_tick(1'b1, 1'b0, 3'd4, 1'b0, 10'd5, 10'd0, 2'd1);
        do_tick(1'b0, 1'b0, 3'd0, 1'b0, 10'd5, 10'd0, 2'd0);
        do_tick(1'b1, 1'b0, 3'd0, 1'b1, 10'd5, 10'd0, 2'd1);
        do_tick(1'b1, 1'b0, 3'd7, 1'b0, 10'd0, 10'd0, 2'd1);
        do_tick(1'b1, 1'b0, 3'd7, 1'b1, 10'd8, 10'd0, 2'd1);
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_restart_collision();
        test_wrap();
        test_pause_disable();
        test_stable_between_ticks();
        test_async_reset();
`ifdef SCROLL_SEQ_BOUNCE_EN
        test_bounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scroll_sequencer.md
Name: scroll_sequencer

Overview:
Frame-synchronous controller that sequences scroll offsets for the VGA pattern datapath. It detects frame starts from the sync generator's vsync, in the clk domain, with no vsync-clocked logic. It runs a fixed program: scroll X, scroll Y, hold, repeat. Its registered offsets feed the pixel pattern adders, so offsets only ever change at frame boundaries.

Parameters:
SEG_FRAMES, 120, frames spent in each of SCROLL_X and SCROLL_Y (legal 1..255)
HOLD_FRAMES, 30, frames spent in HOLD (legal 1..255)
VSYNC_ACTIVE_HIGH, 0, 1: frame tick on vsync rising edge; 0: frame tick on vsync falling edge
X_LIMIT, 639, upper bound for scroll_x in bounce mode only (legal 1..1023)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
vsync  in  1  vsync from hvsync generator, clk domain
enable  in  1  run request, sampled at frame tick
pause  in  1  freeze offsets and segment count, sampled at frame tick
restart  in  1  synchronous single-cycle pulse; clear offsets and return to IDLE
speed  in  3  step per frame = speed+1 (1..8)
dir  in  1  0: increment, 1: decrement
scroll_x  out  10  horizontal offset
scroll_y  out  10  vertical offset
phase  out  2  state: 0 IDLE, 1 SCROLL_X, 2 SCROLL_Y, 3 HOLD
frame_tick  out  1  one-cycle pulse, registered
frame_count  out  16  ticks since reset, wraps at 65535->0

Behaviour:
- rst_n low, asynchronously: all outputs 0, state IDLE, seg_cnt 0, vsync_q at its inactive level.
- vsync_q is a one-cycle delay of vsync. tick is asserted in cycle N when vsync is at its active level and vsync_q is not. All updates below take effect on the clk edge ending cycle N, so they are visible in cycle N+1. frame_tick = 1 in cycle N+1 only.
- Precedence on the same cycle: restart > tick.
- restart, any cycle: scroll_x = scroll_y = 0, state IDLE, seg_cnt 0. frame_count is unchanged. A coincident tick is discarded, so frame_tick stays 0 and frame_count does not increment.
- On every tick without restart: frame_count += 1. Then apply the following in order:
  - enable = 0: state IDLE, seg_cnt 0; offsets hold their values.
  - enable = 1, pause = 1: no change to state, seg_cnt or offsets.
  - IDLE with enable = 1: go to SCROLL_X, seg_cnt 0, no step on this tick.
  - SCROLL_X: scroll_x steps by speed+1 in direction dir. If seg_cnt == SEG_FRAMES-1, go to SCROLL_Y with seg_cnt 0; else seg_cnt += 1.
  - SCROLL_Y: same rule applied to scroll_y; on completion go to HOLD.
  - HOLD: no step. If seg_cnt == HOLD_FRAMES-1, go to SCROLL_X with seg_cnt 0; else seg_cnt += 1.
- Arithmetic: offsets are 10-bit modulo 1024, so increment and decrement both wrap. seg_cnt is 8-bit.
- speed and dir are sampled only at the tick; changes between ticks have no effect.
- Between ticks all outputs are stable (except frame_tick deasserting). No output is combinational from any input.

Optional Feature:
SCROLL_SEQ_BOUNCE_EN
- Defined: scroll_x does not wrap. An internal xdir register is loaded from dir on each IDLE->SCROLL_X transition.
- Each SCROLL_X step uses xdir:
  - forward result > X_LIMIT: clamp to X_LIMIT and flip xdir;
  - reverse result < 0: clamp to 0 and flip xdir.
- The dir input is ignored for X while in SCROLL_X. scroll_y still wraps. restart clears xdir to 0.
- Undefined: no xdir register; X behaves exactly like Y.

Test Plan:
- Reset: assert rst_n low mid-SCROLL_X with scroll_x=37 -> within the same cycle all outputs 0 and phase 0, without waiting for a clk edge.
- Sequence (SEG_FRAMES=4, HOLD_FRAMES=2, speed=0, dir=0, enable=1) -> tick1 phase 1 x=0; ticks 2-5 x=1,2,3,4, phase 2 after tick5; ticks 6-9 y=1..4, phase 3; ticks 10-11 hold, phase 1 after tick11; frame_count=11.
- Wrap: x=1020, speed=7, dir=0, one SCROLL_X tick -> x=4; x=3, dir=1 -> x=1019.
- Pause/disable: pause=1 for 3 ticks in SCROLL_Y at y=10 -> y=10, seg_cnt unchanged, frame_count +3; then enable=0 one tick -> phase 0, y=10 held.
- Restart collision: restart pulsed in the same cycle as a tick, with x=50 -> x=0, phase 0, frame_tick stays 0, frame_count unchanged.
- Bounce (macro defined, X_LIMIT=639): x=636, speed=7, forward -> x=639; next tick x=631; from x=5 reverse speed=7 -> x=0, then 8.
